// File: rtl/spect_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : spect_uart_rx
// Purpose  : Serial receiver on the POSI line feeding the regmap/config logic.
//            Synchronises posi, validates the start bit, samples WIDTH data
//            bits LSB-first at mid-bit and checks the stop bit. Each good word
//            is presented with a one-cycle rx_valid strobe; a stop bit sampled
//            low produces a one-cycle frame_err strobe.
// Optional : UART_RX_PARITY_EN - when defined, one even-parity bit follows the
//            data bits; a mismatch drops the word and pulses parity_err.
//            When undefined, no parity bit is expected and parity_err is 0.
// Ports    : clk        in   1      core clock, rising edge
//            reset      in   1      synchronous, active-high
//            posi       in   1      serial data, asynchronous to clk
//            rx_data    out  WIDTH  last good word, held until next good frame
//            rx_valid   out  1      one-cycle pulse: rx_data updated
//            rx_busy    out  1      high from start detection until IDLE
//            frame_err  out  1      one-cycle pulse: stop bit sampled 0
//            parity_err out  1      one-cycle pulse: parity mismatch
// Revision : 1.0 - initial release
// ============================================================================
module spect_uart_rx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4   // must be even and >= 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             posi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int c_CYC_W = $clog2(CLKS_PER_BIT);
  localparam int c_BIT_W = $clog2(WIDTH + 1);

  // Start bit is checked half a bit in; every later bit one full bit later,
  // which lands all subsequent samples at mid-bit.
  localparam logic [c_CYC_W-1:0] c_CYC_HALF = c_CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_S_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_S_STOP   = 3'd4;

  // Synchroniser
  logic               posi_meta_q;
  logic               posi_s_q;

  // Control
  logic [2:0]         state_q,  state_d;
  logic [c_CYC_W-1:0] cyc_q,    cyc_d;
  logic [c_BIT_W-1:0] bit_q,    bit_d;
  logic               armed_q,  armed_d;

  // Datapath / outputs
  logic [WIDTH-1:0]   sr_q,         sr_d;
  logic [WIDTH-1:0]   rx_data_q,    rx_data_d;
  logic               rx_valid_q,   rx_valid_d;
  logic               rx_busy_q,    rx_busy_d;
  logic               frame_err_q,  frame_err_d;

  logic               w_cyc_half;
  logic               w_cyc_last;
  logic               w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic               par_q,        par_d;
  logic               parity_err_q, parity_err_d;
`endif

  assign w_cyc_half = (cyc_q == c_CYC_HALF);
  assign w_cyc_last = (cyc_q == c_CYC_LAST);

`ifdef UART_RX_PARITY_EN
  // Even parity: data ones plus the parity bit must be an even count.
  assign w_par_bad = par_q ^ (^sr_q);
`else
  assign w_par_bad = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      posi_meta_q  <= 1'b1;
      posi_s_q     <= 1'b1;
      state_q      <= c_S_IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      armed_q      <= 1'b0;
      sr_q         <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      posi_meta_q  <= posi;
      posi_s_q     <= posi_meta_q;
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      armed_q      <= armed_d;
      sr_q         <= sr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_busy_q    <= rx_busy_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    armed_d = 1'b0;

    case (state_q)
      c_S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        // Only a falling edge seen after the line was high starts a frame,
        // so a stuck-low line cannot retrigger endlessly.
        if (armed_q && !posi_s_q) begin
          state_d = c_S_START;
        end else begin
          armed_d = armed_q | posi_s_q;
        end
      end

      c_S_START: begin
        if (w_cyc_half) begin
          cyc_d   = '0;
          state_d = posi_s_q ? c_S_IDLE : c_S_DATA;
        end else begin
          cyc_d = cyc_q + c_CYC_W'(1);
        end
      end

      c_S_DATA: begin
        if (w_cyc_last) begin
          cyc_d = '0;
          if (bit_q == c_BIT_LAST) begin
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = c_S_PARITY;
`else
            state_d = c_S_STOP;
`endif
          end else begin
            bit_d = bit_q + c_BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + c_CYC_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      c_S_PARITY: begin
        if (w_cyc_last) begin
          cyc_d   = '0;
          state_d = c_S_STOP;
        end else begin
          cyc_d = cyc_q + c_CYC_W'(1);
        end
      end
`endif

      c_S_STOP: begin
        // Leaving at the stop-bit mid sample gives half a bit of slack to
        // catch a following start edge with no idle gap.
        if (w_cyc_last) begin
          cyc_d   = '0;
          state_d = c_S_IDLE;
        end else begin
          cyc_d = cyc_q + c_CYC_W'(1);
        end
      end

      default: begin
        state_d = c_S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    sr_d         = sr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    rx_busy_d    = (state_d != c_S_IDLE);
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (w_cyc_last) begin
      case (state_q)
        c_S_DATA: begin
          // LSB arrives first and ends up in bit 0 after WIDTH shifts.
          sr_d = {posi_s_q, sr_q[WIDTH-1:1]};
        end
`ifdef UART_RX_PARITY_EN
        c_S_PARITY: begin
          par_d = posi_s_q;
        end
`endif
        c_S_STOP: begin
          // Framing error takes precedence over parity error.
          if (!posi_s_q) begin
            frame_err_d = 1'b1;
          end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b1;
`endif
          end else begin
            rx_data_d  = sr_q;
            rx_valid_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
